// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_pkg
// Brief    : Shared register offsets and reset constants for the RV32 CLINT.
// Revision : 1.0 - initial release
// ============================================================================
package rv32_pkg;

  // Byte offsets of the CLINT registers within the 64 KiB window
  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  // mtimecmp resets to all ones so the timer interrupt stays quiet until programmed
  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/rv32_clint_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : rv32_clint_prescaler
// Brief    : Divides clk by TICK_DIV and pulses o_tick on each counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam logic [15:0] C_LAST = 16'(TICK_DIV - 1);

  logic [15:0] r_cnt;
  logic        w_wrap;

  assign w_wrap = (r_cnt == C_LAST);
  assign o_tick = w_wrap;

  // Count 0..TICK_DIV-1; a restart (mtime written) forces the phase back to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if (i_restart || w_wrap) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule : rv32_clint_prescaler
`default_nettype wire

// File: rtl/rv32_clint.sv
`default_nettype none
// ============================================================================
// Module   : rv32_clint
// Brief    : RV32 core-local interruptor: MSIP, 64-bit mtime/mtimecmp,
//            single-cycle register bus, registered interrupt lines.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_clint
  import rv32_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [15:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        irq_software,
  output logic        irq_timer
);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [31:0] r_shadow;
  logic        r_msip;
  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_irq_sw;
  logic        r_irq_tm;

  logic [15:0] w_word;
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_mtime_lo;
  logic        w_wr_mtime_hi;
  logic        w_tick;
  logic [31:0] w_rdata;

  // Low address bits are masked off so sub-word offsets alias to their word
  assign w_word        = bus_addr & 16'hFFFC;
  assign w_wr          = bus_req &  bus_we;
  assign w_rd          = bus_req & ~bus_we;
  assign w_wr_mtime_lo = w_wr && (w_word == CLINT_MTIME_LO);
  assign w_wr_mtime_hi = w_wr && (w_word == CLINT_MTIME_HI);

  rv32_clint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_wr_mtime_lo | w_wr_mtime_hi),
    .o_tick    (w_tick)
  );

  // mtime: a software write to either half beats the tick in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime <= 64'd0;
    end else if (w_wr_mtime_lo) begin
      r_mtime[31:0] <= bus_wdata;
    end else if (w_wr_mtime_hi) begin
      r_mtime[63:32] <= bus_wdata;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // mtimecmp halves are written independently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtimecmp <= CLINT_MTIMECMP_RST;
    end else if (w_wr && (w_word == CLINT_MTIMECMP_LO)) begin
      r_mtimecmp[31:0] <= bus_wdata;
    end else if (w_wr && (w_word == CLINT_MTIMECMP_HI)) begin
      r_mtimecmp[63:32] <= bus_wdata;
    end
  end

  // MSIP keeps only bit 0 of the written word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msip <= 1'b0;
    end else if (w_wr && (w_word == CLINT_MSIP)) begin
      r_msip <= bus_wdata[0];
    end
  end

  // Reading MTIME_LO captures the upper half so a following HI read is coherent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= 32'd0;
    end else if (w_rd && (w_word == CLINT_MTIME_LO)) begin
      r_shadow <= r_mtime[63:32];
    end
  end

  // Read-data selection; MTIME_HI returns the shadow, unmapped offsets read 0
  always_comb begin
    w_rdata = 32'd0;
    case (w_word)
      CLINT_MSIP:        w_rdata = {31'd0, r_msip};
      CLINT_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
      CLINT_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
      CLINT_MTIME_LO:    w_rdata = r_mtime[31:0];
      CLINT_MTIME_HI:    w_rdata = r_shadow;
      default:           w_rdata = 32'd0;
    endcase
  end

  // Bus response: one ready pulse per sampled request, data zero otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ready <= bus_req;
      r_rdata <= w_rd ? w_rdata : 32'd0;
    end
  end

  // Interrupt lines are registered from the architectural state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_sw <= 1'b0;
      r_irq_tm <= 1'b0;
    end else begin
      r_irq_sw <= r_msip;
      r_irq_tm <= (r_mtime >= r_mtimecmp);
    end
  end

  assign bus_ready    = r_ready;
  assign bus_rdata    = r_rdata;
  assign irq_software = r_irq_sw;
  assign irq_timer    = r_irq_tm;

endmodule : rv32_clint
`default_nettype wire

// File: doc/rv32_clint.md
RV32_CLINT -- requirements
Module: rv32_clint

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1, meaning clk cycles per mtime increment (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock. All logic is in this domain.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port bus_req, input, 1, access request, sampled on posedge clk.
REQ-005 SHALL have port bus_we, input, 1, 1=write, 0=read.
REQ-006 SHALL have port bus_addr, input, 16, byte offset, word-aligned; bits [1:0] are ignored.
REQ-007 SHALL have port bus_wdata, input, 32, write data; full-word writes only.
REQ-008 SHALL have port bus_rdata, output, 32, read data, valid while bus_ready=1.
REQ-009 SHALL have port bus_ready, output, 1, one-cycle access-completion pulse.
REQ-010 SHALL have port irq_software, output, 1, machine software interrupt line (level).
REQ-011 SHALL have port irq_timer, output, 1, machine timer interrupt line (level).

Function
REQ-012 SHALL implement this register map:
- 0x0000 MSIP: only bit0 is writable; other bits read 0.
- 0x4000 MTIMECMP_LO.
- 0x4004 MTIMECMP_HI.
- 0xBFF8 MTIME_LO.
- 0xBFFC MTIME_HI.
- Any other address reads 0; writes to it are ignored.
REQ-013 SHALL complete every access with bus_ready=1 exactly one cycle after bus_req is sampled.
- bus_rdata is registered.
- bus_req asserted in back-to-back cycles produces back-to-back ready pulses.
- bus_rdata is 0 when bus_ready=0.
REQ-014 SHALL run a prescaler that counts 0..TICK_DIV-1 and raises an internal tick in the cycle it wraps. With TICK_DIV=1, tick is asserted every cycle.
REQ-015 SHALL increment the 64-bit mtime by 1 on each tick. Wrap from 0xFFFF_FFFF_FFFF_FFFF to 0 is silent.
REQ-016 SHALL give a bus write to MTIME_LO or MTIME_HI priority over a tick in the same cycle.
- The written half takes the write data.
- The other half holds its value; no increment occurs that cycle.
- The prescaler restarts at 0.
REQ-017 SHALL snapshot mtime[63:32] into a shadow register when MTIME_LO is read. A read of MTIME_HI returns the shadow, giving a coherent 64-bit read sequence of LO then HI.
REQ-018 SHALL register irq_timer as (mtime >= mtimecmp), unsigned 64-bit compare, evaluated every cycle. Latency is one cycle from the mtime or mtimecmp update to irq_timer.
REQ-019 SHALL register irq_software equal to MSIP bit0. It follows a write one cycle after the write is sampled.
REQ-020 SHALL apply a write to one mtimecmp half independently. Transient assertion of irq_timer between the two half-writes is permitted; software writes HI=0xFFFF_FFFF first.
REQ-021 SHALL leave all state unchanged on reads, except the shadow update defined in REQ-017.

Reset
REQ-022 SHALL, while rst_n=0, hold the following values:
- mtime=0, prescaler=0, shadow=0, MSIP=0.
- mtimecmp=0xFFFF_FFFF_FFFF_FFFF.
- irq_timer=0, irq_software=0.
- bus_ready=0, bus_rdata=0.
REQ-023 SHALL abort any in-flight access when reset is asserted mid-access. No ready pulse is produced after reset is released for that access.

Structure
REQ-024 SHALL place register offsets and reset constants in shared package rv32_pkg:
- CLINT_MSIP, CLINT_MTIMECMP_LO/HI, CLINT_MTIME_LO/HI.
- CLINT_MTIMECMP_RST.
REQ-025 SHALL contain one sub-module, rv32_clint_prescaler, which takes TICK_DIV and drives tick. Everything else is inline.
REQ-026 SHALL target 120-400 lines of RTL with no latches. All flops use the async rst_n.

Verification
REQ-027 Reset: after reset release with no access, expect irq_timer=0, irq_software=0, and a read of MTIME_LO after 10 cycles (TICK_DIV=1) returning 10 ± 1.
REQ-028 Timer compare:
- Write MTIMECMP_HI=0, then MTIMECMP_LO=100.
- Expect irq_timer to rise one cycle after mtime reaches 100.
- Then write MTIMECMP_HI=1; expect irq_timer=0 one cycle later.
REQ-029 Software IRQ: write MSIP=0xFFFF_FFFF -> irq_software=1 next cycle and a read returns 0x1. Write 0 -> irq_software drops next cycle.
REQ-030 Wrap and coherent read:
- Write MTIME_HI=0xFFFF_FFFF and MTIME_LO=0xFFFF_FFFE.
- Read LO then HI across the wrap; the HI value returned matches the snapshot taken at the LO read.
- mtime wraps to 0 without error.
REQ-031 Write vs tick collision (TICK_DIV=4):
- Write MTIME_LO=5 in a tick cycle -> read back 5, with no increment for 4 cycles.
- Back-to-back requests each get exactly one ready pulse.
REQ-032 Mid-access reset: assert rst_n=0 on the cycle after bus_req -> bus_ready stays 0, and all registers equal the REQ-022 values.
